// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0]  BCD_ERR_NIBBLE = 4'hE;
  localparam logic [26:0] BCD_MAX_8DIG   = 27'd99_999_999;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble when it is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock, start/busy/done
// handshake; the result register only changes on the done edge.
import bcd_pkg::*;

module bin_to_bcd_seq #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int          CW   = cnt_w(WIDTH);
  localparam logic [63:0] MAXV = bcd_max(DIGITS);

  state_t                   state, state_nxt;
  logic                     accept;
  logic [WIDTH-1:0]         binreg;
  logic [DIGITS-1:0][3:0]   scr, corr;
  logic [4*DIGITS-1:0]      corr_flat, shifted;
  logic [CW-1:0]            cnt;
  logic                     ovf_pend;
  logic                     last;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_add3 u_add3 (.din(scr[g]), .dout(corr[g]));
    end
  endgenerate

  assign corr_flat = corr;
  // Binary MSB feeds the scratch LSB; the top corrected bit falls off.
  assign shifted   = (corr_flat << 1) | {{(4*DIGITS-1){1'b0}}, binreg[WIDTH-1]};
  assign last      = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = SHIFT;
        accept    = 1'b1;
      end
      SHIFT: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binreg   <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        binreg   <= bin;
        scr      <= '0;
        cnt      <= '0;
        ovf_pend <= (64'(bin) > MAXV);
        busy     <= 1'b1;
      end else if (state == SHIFT) begin
        scr    <= shifted;
        binreg <= binreg << 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          // Timing is identical on overflow; only the written word differs.
          bcd  <= ovf_pend ? {DIGITS{BCD_ERR_NIBBLE}} : shifted;
          ovf  <= ovf_pend;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, busy width, results, overflow,
// ignored start, back-to-back and mid-conversion reset.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [26:0] bin;
  logic        busy, done, ovf;
  logic [31:0] bcd;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  bin_to_bcd_seq #(.WIDTH(27), .DIGITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Start one conversion and follow it to done; checks latency, busy width,
  // result, overflow flag and the one-cycle done pulse.
  task automatic run_conv(input string name, input logic [26:0] v,
                          input logic [31:0] exp_bcd, input logic exp_ovf);
    int edges, nbusy;
    bit got;
    bin = v; start = 1'b1;
    tick();
    start = 1'b0; bin = 27'h5A5A5A5;
    edges = 1; nbusy = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (done) begin got = 1; break; end
      tick(); edges++;
    end
    tot_cnt++;
    if (!got) $display("FAIL %s_timeout: no done within 40 cycles", name);
    else pass_cnt++;
    chk({name, "_latency"}, edges, 28);
    chk({name, "_busy_cycles"}, nbusy, 27);
    chk({name, "_bcd"}, bcd, exp_bcd);
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    tick();
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, "_bcd_hold"}, bcd, exp_bcd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bin = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_bcd",  bcd, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_convert();
    run_conv("zero",  27'd0,          32'h00000000, 1'b0);
    run_conv("n1234", 27'd12_345_678, 32'h12345678, 1'b0);
    run_conv("max",   27'd99_999_999, 32'h99999999, 1'b0);
  endtask

  task automatic test_overflow();
    run_conv("ovf",   27'd100_000_000, 32'hEEEEEEEE, 1'b1);
    run_conv("after", 27'd42,          32'h00000042, 1'b0);
  endtask

  task automatic test_start_ignored();
    int ndone;
    bin = 27'd500; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bin = 27'd777; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_bcd", bcd, 32'h00000500);
  endtask

  task automatic test_back_to_back();
    int t, t1, t2, n;
    bin = 27'd1234; start = 1'b1;
    tick();
    t = 1; n = 0; t1 = 0; t2 = 0;
    while (n < 2 && t < 100) begin
      if (done) begin
        n++;
        if (n == 1) t1 = t;
        else begin t2 = t; start = 1'b0; end
        chk($sformatf("b2b_bcd%0d", n), bcd, 32'h00001234);
      end
      tick(); t++;
    end
    start = 1'b0;
    chk("b2b_count", n, 2);
    chk("b2b_spacing", t2 - t1, 28);
    for (int i = 0; i < 3; i++) tick();
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_mid_reset();
    int ndone;
    bin = 27'd55; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_ovf",  {31'd0, ovf},  32'd0);
    chk("mrst_bcd",  bcd, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("mrst_no_done", ndone, 0);
    run_conv("post_rst", 27'd9, 32'h00000009, 1'b0);
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment display driver. It takes an unsigned binary amount (account balance, withdrawal amount) and produces the 32-bit packed BCD word the display driver consumes as its `x` input, with nibble 0 as the rightmost digit. The conversion uses iterative double-dabble (shift-and-add-3), one input bit per clock, with a start/busy/done handshake. The result register holds its value between conversions so the display never sees intermediate data.

## Interface
- `WIDTH`, 27: binary input width; must satisfy 2^WIDTH ≥ 10^DIGITS.
- `DIGITS`, 8: number of BCD digits; output width is 4*DIGITS.
- `clk`  in  1  system clock, shared with the display driver.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bin`  in  WIDTH  unsigned binary value; sampled on the accepting edge only.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; `bcd` and `ovf` are valid from this cycle on.
- `bcd`  out  4*DIGITS  packed BCD result, registered; feeds display `x`.
- `ovf`  out  1  last accepted `bin` exceeded 10^DIGITS−1.

## Operation
- States: IDLE, SHIFT.
- IDLE with `start`=1:
  - Load `bin` into the shift register.
  - Clear the scratch BCD register and set the bit counter to 0.
  - Latch `ovf_pending` = (`bin` > 10^DIGITS−1).
  - Go to SHIFT and set `busy`=1.
- IDLE with `start`=0: hold all outputs.
- SHIFT, each edge:
  - Every scratch nibble ≥ 5 gets +3 (4-bit add, no carry between nibbles).
  - Shift {scratch, binreg} left by 1. The binary MSB enters the scratch LSB.
  - Increment the counter.
- SHIFT, on the edge where counter = WIDTH−1 (final iteration):
  - Write `bcd` = corrected-and-shifted scratch, or 0xE in every nibble if `ovf_pending`.
  - Set `ovf` = `ovf_pending` and `done`=1, clear `busy`, return to IDLE.
- `start` while `busy`=1: ignored, no queuing; `bin` may change freely.
- `start` during the `done` cycle: accepted (FSM is in IDLE); back-to-back conversions are legal.
- `bcd` and `ovf` change only on the `done` edge. They hold until the next `done`.
- Overflow: conversion timing is identical; only the written value differs. The error pattern shows as "EEEEEEEE" on the display.
- Reset (`rst_n`=0 at a rising edge), also mid-conversion:
  - State → IDLE.
  - `busy`=0, `done`=0, `ovf`=0, `bcd`=0, counter and scratch cleared.
  - An aborted conversion produces no `done`.

## Timing
- Accepting edge E0 (IDLE, `start`=1): `busy` reads 1 from E0+ onward.
- Iterations occur on edges E1..E_WIDTH.
- `done`=1 and the new `bcd`/`ovf` appear after edge E_WIDTH (E27 by default). `done` lasts exactly one cycle; `busy` drops on that same edge.
- Latency: WIDTH+1 edges from acceptance to the `done` cycle, 28 by default. Throughput: one conversion per WIDTH+1 cycles.
- Add-3 correction and shift complete in one cycle: DIGITS parallel 4-bit compare/add, no multi-cycle paths.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `bcd_pkg`:
  - state enum {IDLE, SHIFT}
  - `BCD_ERR_NIBBLE` = 4'hE
  - `BCD_MAX_8DIG` = 27'd99_999_999
  - helper function or localparam for the counter width, $clog2(WIDTH).
- One sub-module, `bcd_add3`: 4-bit in, 4-bit out, adds 3 when input ≥ 5. Instantiated DIGITS times via generate.
- Top holds the FSM, counter, shift register, and output registers.

## Test plan
- Reset, then `bin`=0, `start` one cycle → `done` at edge 28, `bcd`=0x00000000, `ovf`=0.
- `bin`=12_345_678 → `bcd`=0x12345678. `bin`=99_999_999 → `bcd`=0x99999999, `ovf`=0. Check `busy` is high for exactly 27 cycles each time.
- `bin`=100_000_000 → `bcd`=0xEEEEEEEE, `ovf`=1. A following `bin`=42 → `bcd`=0x00000042, `ovf`=0.
- `start` for `bin`=500, then at cycle 5 assert `start` with `bin`=777 → only one `done`, `bcd`=0x00000500.
- `start` with `bin`=1234 held high continuously → back-to-back `done` pulses spaced 28 cycles apart, `bcd`=0x00001234 each time.
- Mid-conversion `rst_n`=0 at cycle 10 after `bin`=55 → next cycle all outputs 0 and no `done`. A new `start` with `bin`=9 → `bcd`=0x00000009 after 28 cycles.
